// File: rtl/ga_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ga_sync_pkg
// Description : Shared constants and helpers for the Gate Array sync and
//               interrupt processor (HSYNC/VSYNC shaping, 52-line raster
//               interrupt, screen-mode latch).
// Revision    : 1.0 - initial release
// ============================================================================
package ga_sync_pkg;

    // Raster interrupt: one request every INT_LINES HSYNC falls. A VSYNC
    // resync raises an early request only if the counter is at or past
    // INT_THRESH.
    localparam logic [5:0] INT_LINES  = 6'd52;
    localparam logic [5:0] INT_THRESH = 6'd32;

    // Monitor HSYNC window, in CLKEN ticks after the CRTC HSYNC rise.
    localparam logic [3:0] HS_DELAY   = 4'd2;
    localparam logic [3:0] HS_WIDTH   = 4'd4;

    // Monitor VSYNC window, in HSYNC falls after the CRTC VSYNC rise.
    localparam logic [2:0] VS_DELAY   = 3'd2;
    localparam logic [2:0] VS_WIDTH   = 3'd4;

    typedef logic [1:0] ga_mode_t;

    // True while the HSYNC tick counter lies inside the monitor HSYNC window.
    function automatic logic hs_in_window(input logic [3:0] cnt);
        return (cnt >= HS_DELAY) && (cnt <= (HS_DELAY + HS_WIDTH - 4'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ga_sync_processor_if.sv
`default_nettype none
// ============================================================================
// Module      : ga_sync_processor_if
// Description : Signal bundle between the CRTC/Z80 side and the Gate Array
//               sync processor. The master modport drives the CRTC sync
//               pulses, CLKEN and the Z80/RMR strobes; the slave modport
//               (the sync processor) returns monitor syncs, the interrupt
//               request, the effective screen mode and the line counter.
//   CLKEN       1 MHz character strobe shared with the CRTC
//   CRTC_HSYNC  CRTC horizontal sync, active high
//   CRTC_VSYNC  CRTC vertical sync, active high
//   INT_ACK     Z80 interrupt acknowledge, single-CLOCK pulse
//   INT_CLR     RMR write with bit4 set, single-CLOCK pulse
//   MODE_WR     RMR write strobe, single-CLOCK pulse
//   MODE_IN     requested screen mode
//   HSYNC_OUT   monitor HSYNC
//   VSYNC_OUT   monitor VSYNC
//   CSYNC       HSYNC_OUT xor VSYNC_OUT
//   INT         Z80 interrupt request
//   MODE        effective screen mode
//   INT_CNT     interrupt line counter
// Revision    : 1.0 - initial release
// ============================================================================
interface ga_sync_processor_if;
    import ga_sync_pkg::*;

    logic       CLKEN;
    logic       CRTC_HSYNC;
    logic       CRTC_VSYNC;
    logic       INT_ACK;
    logic       INT_CLR;
    logic       MODE_WR;
    ga_mode_t   MODE_IN;
    logic       HSYNC_OUT;
    logic       VSYNC_OUT;
    logic       CSYNC;
    logic       INT;
    ga_mode_t   MODE;
    logic [5:0] INT_CNT;

    modport master (
        output CLKEN, CRTC_HSYNC, CRTC_VSYNC, INT_ACK, INT_CLR, MODE_WR, MODE_IN,
        input  HSYNC_OUT, VSYNC_OUT, CSYNC, INT, MODE, INT_CNT
    );

    modport slave (
        input  CLKEN, CRTC_HSYNC, CRTC_VSYNC, INT_ACK, INT_CLR, MODE_WR, MODE_IN,
        output HSYNC_OUT, VSYNC_OUT, CSYNC, INT, MODE, INT_CNT
    );

endinterface
`default_nettype wire

// File: rtl/ga_int_counter.sv
`default_nettype none
// ============================================================================
// Module      : ga_int_counter
// Description : 6-bit raster interrupt line counter and INT flag.
//   CLOCK       system clock
//   nRESET      synchronous active-low reset
//   i_hs_fall   CLKEN-qualified CRTC HSYNC fall
//   i_vs_reset  HSYNC fall on which the VSYNC sequence resyncs the counter
//   i_int_ack   Z80 acknowledge: clears INT and counter bit 5
//   i_int_clr   RMR clear: clears INT and the whole counter
//   o_int       interrupt request
//   o_int_cnt   line counter value
// Priority: reset, clear, counter event, acknowledge. An acknowledge in the
// same cycle as a new request leaves INT set, and its bit-5 clear acts on
// the post-event counter value.
// Revision    : 1.0 - initial release
// ============================================================================
module ga_int_counter
    import ga_sync_pkg::*;
(
    input  wire logic       CLOCK,
    input  wire logic       nRESET,
    input  wire logic       i_hs_fall,
    input  wire logic       i_vs_reset,
    input  wire logic       i_int_ack,
    input  wire logic       i_int_clr,
    output logic            o_int,
    output logic [5:0]      o_int_cnt
);

    logic [5:0] r_cnt;
    logic       r_int;

    logic [5:0] w_cnt_evt;
    logic       w_set;
    logic [5:0] w_cnt_nxt;
    logic       w_int_nxt;

    always_comb begin
        w_cnt_evt = r_cnt;
        w_set     = 1'b0;
        if (i_hs_fall) begin
            if (i_vs_reset) begin
                // VSYNC resync: counter always restarts, early request only
                // when the current frame position is late enough.
                w_cnt_evt = 6'd0;
                w_set     = (r_cnt >= INT_THRESH);
            end else if ((r_cnt + 6'd1) == INT_LINES) begin
                w_cnt_evt = 6'd0;
                w_set     = 1'b1;
            end else begin
                w_cnt_evt = r_cnt + 6'd1;
            end
        end

        w_cnt_nxt = w_cnt_evt;
        w_int_nxt = r_int | w_set;
        if (i_int_ack) begin
            w_cnt_nxt[5] = 1'b0;
            if (!w_set) begin
                w_int_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            r_cnt <= 6'd0;
            r_int <= 1'b0;
        end else if (i_int_clr) begin
            r_cnt <= 6'd0;
            r_int <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_int <= w_int_nxt;
        end
    end

    assign o_int     = r_int;
    assign o_int_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ga_sync_processor.sv
`default_nettype none
// ============================================================================
// Module      : ga_sync_processor
// Description : Gate Array sync and interrupt processor. Samples the CRTC
//               HSYNC/VSYNC on CLKEN, shapes the monitor HSYNC/VSYNC/CSYNC,
//               drives the 52-line raster interrupt and latches the screen
//               mode on HSYNC rise.
//   CLOCK       system clock
//   nRESET      synchronous active-low reset
//   bus         ga_sync_processor_if.slave (CLKEN, CRTC syncs, INT_ACK,
//               INT_CLR, MODE_WR/MODE_IN in; HSYNC_OUT, VSYNC_OUT, CSYNC,
//               INT, MODE, INT_CNT out)
// Build option: GA_SYNC_CUT_EN - GA40010 behaviour: monitor HSYNC is gated
//               by CRTC_HSYNC and monitor VSYNC ends as soon as CRTC_VSYNC
//               is seen low. Undefined: fixed 4-tick HSYNC, 4-line VSYNC.
// Revision    : 1.0 - initial release
// ============================================================================
module ga_sync_processor
    import ga_sync_pkg::*;
(
    input  wire logic           CLOCK,
    input  wire logic           nRESET,
    ga_sync_processor_if.slave  bus
);

    logic       r_hs_d;
    logic       r_vs_d;
    logic       r_hs_arm;       // CRTC_HSYNC seen low since reset
    logic [3:0] r_hcnt;
    logic [2:0] r_vhs;
    logic       r_armed;
    ga_mode_t   r_mode_pend;
    ga_mode_t   r_mode;
    logic       r_hsync_out;
    logic       r_vsync_out;

    logic       w_hs_rise;
    logic       w_hs_fall;
    logic       w_vs_rise;
    logic       w_vs_cut;
    logic       w_vs_step;
    logic       w_vs_reset;
    logic [2:0] w_vhs_inc;
    logic       w_hcnt_go;
    logic [3:0] w_hcnt_nxt;
    logic       w_hsync_nxt;
    logic       w_int;
    logic [5:0] w_int_cnt;

    // A pulse already high when reset ends must not look like a rise, so the
    // edge history only follows CRTC_HSYNC once it has been seen low.
    assign w_hs_rise = bus.CLKEN &  bus.CRTC_HSYNC & ~r_hs_d & r_hs_arm;
    assign w_hs_fall = bus.CLKEN & ~bus.CRTC_HSYNC &  r_hs_d;
    assign w_vs_rise = bus.CLKEN &  bus.CRTC_VSYNC & ~r_vs_d;
    assign w_vhs_inc = r_vhs + 3'd1;

`ifdef GA_SYNC_CUT_EN
    assign w_vs_cut  = bus.CLKEN & ~bus.CRTC_VSYNC & r_armed;
    assign w_hcnt_go = r_hs_arm & bus.CRTC_HSYNC;
`else
    assign w_vs_cut  = 1'b0;
    // Once the window has been reached the count runs on to saturation, so
    // the monitor pulse keeps its full width after an early CRTC fall.
    assign w_hcnt_go = r_hs_arm & (bus.CRTC_HSYNC | (r_hcnt >= HS_DELAY));
`endif

    // A VS rise on the same tick as an HS fall restarts the sequence; that
    // fall is not counted as a VSYNC line.
    assign w_vs_step  = w_hs_fall & r_armed & ~w_vs_rise & ~w_vs_cut;
    assign w_vs_reset = w_vs_step & (w_vhs_inc == VS_DELAY);

    always_comb begin
        w_hcnt_nxt = r_hcnt;
        if (w_hs_rise) begin
            w_hcnt_nxt = 4'd0;
        end else if (w_hcnt_go && (r_hcnt != 4'hF)) begin
            w_hcnt_nxt = r_hcnt + 4'd1;
        end
    end

`ifdef GA_SYNC_CUT_EN
    assign w_hsync_nxt = hs_in_window(w_hcnt_nxt) & bus.CRTC_HSYNC;
`else
    assign w_hsync_nxt = hs_in_window(w_hcnt_nxt);
`endif

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            r_hs_d      <= 1'b0;
            r_vs_d      <= 1'b0;
            r_hs_arm    <= 1'b0;
            r_hcnt      <= 4'd0;
            r_vhs       <= 3'd0;
            r_armed     <= 1'b0;
            r_mode_pend <= 2'd0;
            r_mode      <= 2'd0;
            r_hsync_out <= 1'b0;
            r_vsync_out <= 1'b0;
        end else begin
            if (bus.MODE_WR) begin
                r_mode_pend <= bus.MODE_IN;
            end
            // A write landing on the HS-rise cycle goes straight through.
            if (w_hs_rise) begin
                r_mode <= bus.MODE_WR ? bus.MODE_IN : r_mode_pend;
            end

            if (bus.CLKEN) begin
                r_hs_d      <= bus.CRTC_HSYNC & r_hs_arm;
                r_vs_d      <= bus.CRTC_VSYNC;
                if (!bus.CRTC_HSYNC) begin
                    r_hs_arm <= 1'b1;
                end
                r_hcnt      <= w_hcnt_nxt;
                r_hsync_out <= w_hsync_nxt;

                if (w_vs_rise) begin
                    r_vhs   <= 3'd0;
                    r_armed <= 1'b1;
                end else if (w_vs_cut) begin
                    r_armed     <= 1'b0;
                    r_vsync_out <= 1'b0;
                end else if (w_vs_step) begin
                    r_vhs <= w_vhs_inc;
                    if (w_vhs_inc == VS_DELAY) begin
                        r_vsync_out <= 1'b1;
                    end
                    if (w_vhs_inc == (VS_DELAY + VS_WIDTH)) begin
                        r_vsync_out <= 1'b0;
                        r_armed     <= 1'b0;
                    end
                end
            end
        end
    end

    ga_int_counter u_int_counter (
        .CLOCK      (CLOCK),
        .nRESET     (nRESET),
        .i_hs_fall  (w_hs_fall),
        .i_vs_reset (w_vs_reset),
        .i_int_ack  (bus.INT_ACK),
        .i_int_clr  (bus.INT_CLR),
        .o_int      (w_int),
        .o_int_cnt  (w_int_cnt)
    );

    assign bus.HSYNC_OUT = r_hsync_out;
    assign bus.VSYNC_OUT = r_vsync_out;
    assign bus.CSYNC     = r_hsync_out ^ r_vsync_out;
    assign bus.INT       = w_int;
    assign bus.MODE      = r_mode;
    assign bus.INT_CNT   = w_int_cnt;

endmodule
`default_nettype wire

// File: doc/ga_sync_processor.md
# ga_sync_processor

Gate Array sync and interrupt processor. It sits downstream of the CRTC and consumes the CRTC's raw HSYNC/VSYNC pulses. It produces the monitor HSYNC/VSYNC/CSYNC, the 52-line Z80 raster interrupt and the HSYNC-aligned screen-mode latch. All sequential logic runs on CLOCK and advances on the same character-rate CLKEN that drives the CRTC.

## Interface
Parameters:
- none; all constants come from the shared package.

Ports:
- CLOCK  in  1  system clock.
- nRESET  in  1  reset, synchronous, active-low.
- CLKEN  in  1  1 MHz character strobe, the same one fed to the CRTC.
- CRTC_HSYNC  in  1  CRTC horizontal sync, active high.
- CRTC_VSYNC  in  1  CRTC vertical sync, active high.
- INT_ACK  in  1  Z80 interrupt acknowledge, single-CLOCK pulse, not CLKEN-gated.
- INT_CLR  in  1  RMR write with bit4 set, single-CLOCK pulse.
- MODE_WR  in  1  RMR write strobe, single-CLOCK pulse.
- MODE_IN  in  2  requested screen mode.
- HSYNC_OUT  out  1  monitor HSYNC, active high.
- VSYNC_OUT  out  1  monitor VSYNC, active high.
- CSYNC  out  1  HSYNC_OUT XOR VSYNC_OUT, combinational.
- INT  out  1  Z80 interrupt request, active high.
- MODE  out  2  effective screen mode.
- INT_CNT  out  6  interrupt line counter, for debug and status.

## Operation
- Input edges are sampled only on CLKEN.
  - hs_d and vs_d register CRTC_HSYNC and CRTC_VSYNC on CLKEN.
  - HS rise = CRTC_HSYNC & ~hs_d; HS fall = ~CRTC_HSYNC & hs_d; VS rise is defined the same way from CRTC_VSYNC and vs_d.
- HSYNC shaping:
  - 4-bit hcnt clears on HS rise and increments on each following CLKEN while CRTC_HSYNC is high, saturating at 15.
  - HSYNC_OUT = 1 while hcnt is in [HS_DELAY, HS_DELAY+HS_WIDTH-1], i.e. [2,5].
- Interrupt counter (6-bit):
  - On HS fall: if INT_CNT+1 == 52, then INT_CNT becomes 0 and INT becomes 1; otherwise INT_CNT increments.
- VSYNC handling:
  - VS rise clears 3-bit vhs and arms the VSYNC sequence; vhs increments on each HS fall while armed.
  - On the HS fall where vhs reaches VS_DELAY (2): if INT_CNT ≥ 32, INT becomes 1. INT_CNT becomes 0 unconditionally, overriding the normal increment. VSYNC_OUT becomes 1.
  - On the HS fall where vhs reaches VS_DELAY+VS_WIDTH (6): VSYNC_OUT becomes 0 and the sequence disarms.
  - A VS rise while armed restarts the sequence.
- INT_ACK clears INT and INT_CNT[5].
- INT_CLR clears INT and INT_CNT.
- Mode latch:
  - MODE_WR stores MODE_IN into mode_pend.
  - On HS rise, MODE takes mode_pend.
  - If MODE_WR and HS rise fall on the same CLOCK, MODE takes the new MODE_IN.
- Priority within one CLOCK, highest first: nRESET, INT_CLR, counter event, INT_ACK.
  - When a counter event sets INT in the same cycle as INT_ACK, INT stays 1 so the new interrupt is not lost.
  - INT_ACK's INT_CNT[5] clear applies to the post-event value.

## Timing
- Reset values:
  - HSYNC_OUT=0, VSYNC_OUT=0, CSYNC=0, INT=0, MODE=0, INT_CNT=0.
  - Internally hs_d, vs_d, hcnt, vhs, mode_pend and armed are all 0.
- HSYNC_OUT:
  - Rises on the CLKEN tick 2 ticks after the HS-rise tick.
  - Lasts 4 CLKEN periods; all outputs are registered.
- INT rises on the CLKEN tick that detects the 52nd HS fall.
- INT_ACK and INT_CLR take effect on the next CLOCK edge, independent of CLKEN.
- VSYNC_OUT:
  - Rises at the 2nd HS fall after VS rise.
  - Falls at the 6th, i.e. a width of 4 lines.
- MODE changes on the CLKEN tick of HS rise, never mid-line.
- A CRTC HSYNC shorter than 3 ticks produces no monitor HSYNC.
- Reset mid-pulse: outputs drop on the next CLOCK edge. If CRTC_HSYNC is still high after reset, it does not count as an HS rise until it has been low for one tick.

## Configuration
- Macro GA_SYNC_CUT_EN.
- Defined (GA40010 behaviour):
  - HSYNC_OUT additionally requires CRTC_HSYNC high, so a short CRTC pulse truncates it.
  - VSYNC_OUT is forced to 0 and the sequence disarms at the first CLKEN tick where CRTC_VSYNC is low.
- Undefined:
  - Fixed widths: HSYNC_OUT window stays [2,5] regardless of CRTC_HSYNC length, provided the pulse lasted at least 3 ticks.
  - VSYNC_OUT is always 4 lines.
  - hcnt keeps counting after HS fall until it saturates.

## Structure
- Package ga_sync_pkg holds the constants INT_LINES=52, INT_THRESH=32, HS_DELAY=2, HS_WIDTH=4, VS_DELAY=2, VS_WIDTH=4.
- Sub-module ga_int_counter:
  - Contains the 6-bit counter, INT flag, ack/clear priority and VSYNC reset.
  - Inputs: hs_fall, vs_reset, INT_ACK, INT_CLR.
  - Outputs: INT, INT_CNT.
- The top level holds edge detection, HSYNC/VSYNC shaping and the mode latch.

## Test plan
- CRTC HSYNC width 14 every 64 ticks, no VSYNC:
  - HSYNC_OUT rises 2 ticks after CRTC_HSYNC and is high for exactly 4 ticks.
  - INT pulses on every 52nd HS fall; INT_CNT wraps 51→0.
- INT_CNT=40 at VS rise:
  - After the 2nd HS fall, INT=1, INT_CNT=0 and VSYNC_OUT=1.
  - VSYNC_OUT=0 after the 6th HS fall.
- Repeat the previous case with INT_CNT=20 at VS rise: INT stays 0 and INT_CNT becomes 0.
- INT_CNT=35 and INT=1, then INT_ACK: INT=0 and INT_CNT=3.
- INT_ACK on the same cycle as the 52nd HS fall: INT remains 1.
- MODE_WR with 2 mid-line: MODE stays 0 until the next HS rise tick, then becomes 2.
- CRTC_HSYNC width 3 and CRTC_VSYNC width 2 lines:
  - With GA_SYNC_CUT_EN: HSYNC_OUT is high for 1 tick and VSYNC_OUT never asserts.
  - Without GA_SYNC_CUT_EN: HSYNC_OUT is high for 4 ticks and VSYNC_OUT for 4 lines.
